// File: rtl/i2s_tx_fifo.sv
// I2S / left-justified stereo transmitter with a sample-pair FIFO; SCLK/LRCK/SDIN are registered from i_Clk.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating o_UnderrunCount port.
module i2s_tx_fifo #(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int SCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Valid,
    output logic                o_Ready,
    input  logic [SAMPLE_W-1:0] i_LeftData,
    input  logic [SAMPLE_W-1:0] i_RightData,
    input  logic                i_LeftJustified,
    output logic                o_SDIN,
    output logic                o_SCLK,
    output logic                o_LRCK,
    output logic                o_Underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         o_UnderrunCount
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_W);
    localparam int FW = 2 * SLOT_W;

    localparam logic [CW-1:0] DIV_LAST  = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] DIV_HALF  = CW'(SCLK_DIV / 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] B_LAST    = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] B_SLOT    = BW'(SLOT_W);
    localparam logic [BW-1:0] B_SLOT_M1 = BW'(SLOT_W - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    logic [CW-1:0]       divCnt;
    logic [CW-1:0]       nextCnt;
    logic                fallEvent;
    logic [BW-1:0]       bitIdx;
    logic [BW-1:0]       nextBit;
    logic                frameStart;
    logic                lrckNext;
    logic [AW:0]         wrPtr;
    logic [AW:0]         rdPtr;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [SAMPLE_W-1:0] memLeft  [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] memRight [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] popLeft;
    logic [SAMPLE_W-1:0] popRight;
    logic [FW-1:0]       loadWord;
    logic [FW-1:0]       shiftReg;
    logic                modeReg;

    // Slot image: left-justified puts the MSB at slot bit 0, I2S delays it by one bit; the tail is zero.
    function automatic logic [SLOT_W-1:0] slotBits(input logic [SAMPLE_W-1:0] sample, input logic leftJust);
        logic [SLOT_W+SAMPLE_W-1:0] ext;
        ext = {sample, {SLOT_W{1'b0}}};
        if (leftJust)
            return ext[SLOT_W+SAMPLE_W-1 -: SLOT_W];
        return {1'b0, ext[SLOT_W+SAMPLE_W-1 -: SLOT_W-1]};
    endfunction

    assign fallEvent  = (divCnt == DIV_LAST);
    assign nextCnt    = fallEvent ? '0 : divCnt + CNT_ONE;
    assign nextBit    = (bitIdx == B_LAST) ? '0 : bitIdx + BIT_ONE;
    assign frameStart = fallEvent && (bitIdx == B_LAST);

    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign empty   = (wrPtr == rdPtr);
    assign o_Ready = !full;
    assign push    = i_Valid && !full;
    assign pop     = frameStart && !empty;

    assign popLeft  = empty ? '0 : memLeft[rdPtr[AW-1:0]];
    assign popRight = empty ? '0 : memRight[rdPtr[AW-1:0]];
    assign loadWord = {slotBits(popLeft, i_LeftJustified), slotBits(popRight, i_LeftJustified)};

    // I2S moves the word-select edges one bit ahead of the slot boundaries.
    assign lrckNext = frameStart ? 1'b0 :
                      modeReg    ? (nextBit >= B_SLOT) :
                                   ((nextBit >= B_SLOT_M1) && (nextBit != B_LAST));

    always_ff @(posedge i_Clk) begin
        if (push) begin
            memLeft[wrPtr[AW-1:0]]  <= i_LeftData;
            memRight[wrPtr[AW-1:0]] <= i_RightData;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            divCnt     <= '0;
            bitIdx     <= B_LAST;
            wrPtr      <= '0;
            rdPtr      <= '0;
            shiftReg   <= '0;
            modeReg    <= 1'b0;
            o_SCLK     <= 1'b0;
            o_LRCK     <= 1'b0;
            o_SDIN     <= 1'b0;
            o_Underrun <= 1'b0;
        end else begin
            divCnt     <= nextCnt;
            o_SCLK     <= (nextCnt >= DIV_HALF);
            o_Underrun <= frameStart && empty;
            if (push)
                wrPtr <= wrPtr + PTR_ONE;
            if (pop)
                rdPtr <= rdPtr + PTR_ONE;
            if (fallEvent) begin
                bitIdx <= nextBit;
                o_LRCK <= lrckNext;
                if (frameStart) begin
                    modeReg  <= i_LeftJustified;
                    o_SDIN   <= loadWord[FW-1];
                    shiftReg <= loadWord << 1;
                end else begin
                    o_SDIN   <= shiftReg[FW-1];
                    shiftReg <= shiftReg << 1;
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            o_UnderrunCount <= '0;
        else if (frameStart && empty && (o_UnderrunCount != 16'hFFFF))
            o_UnderrunCount <= o_UnderrunCount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Randomized bench for i2s_tx_fifo: a default instance (A) and a 16/16/2 instance (B) checked every cycle
// against a frame-level model built from bit-index arithmetic and a queue of pushed pairs.
module tb_i2s_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic [1:0]  valid, ready, lj, sdin, sclk, lrck, und;
    logic [23:0] leftA, rightA;
    logic [15:0] leftB, rightB;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cntA, cntB;
`endif

    i2s_tx_fifo dutA (
        .i_Clk(clk), .i_Rst_n(rstN), .i_Valid(valid[0]), .o_Ready(ready[0]),
        .i_LeftData(leftA), .i_RightData(rightA), .i_LeftJustified(lj[0]),
        .o_SDIN(sdin[0]), .o_SCLK(sclk[0]), .o_LRCK(lrck[0]), .o_Underrun(und[0])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .o_UnderrunCount(cntA)
`endif
    );

    i2s_tx_fifo #(.SAMPLE_W(16), .SLOT_W(16), .SCLK_DIV(2), .FIFO_DEPTH(4)) dutB (
        .i_Clk(clk), .i_Rst_n(rstN), .i_Valid(valid[1]), .o_Ready(ready[1]),
        .i_LeftData(leftB), .i_RightData(rightB), .i_LeftJustified(lj[1]),
        .o_SDIN(sdin[1]), .o_SCLK(sclk[1]), .o_LRCK(lrck[1]), .o_Underrun(und[1])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .o_UnderrunCount(cntB)
`endif
    );

    int testsRun = 0;
    int failCount = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          nCyc[2];
    logic [63:0] curPair[2];
    logic        curMode[2];
    logic        expUnd[2];
    int          undCnt[2];

    function automatic int cfgW(int u); return (u == 0) ? 24 : 16; endfunction
    function automatic int cfgS(int u); return (u == 0) ? 32 : 16; endfunction
    function automatic int cfgD(int u); return (u == 0) ? 4 : 2; endfunction

    function automatic string unitTag(string base, int u);
        return $sformatf("%s%s", base, (u == 0) ? "A" : "B");
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int qSize(int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic modelReset();
        q0.delete();
        q1.delete();
        for (int u = 0; u < 2; u++) begin
            nCyc[u]    = 0;
            curPair[u] = '0;
            curMode[u] = 1'b0;
            expUnd[u]  = 1'b0;
            undCnt[u]  = 0;
        end
    endtask

    // One clock edge of the reference: frame start pops (or underruns), then the push lands.
    task automatic modelEdge(input int u);
        logic pushNow;
        int   d, s;
        d = cfgD(u);
        s = cfgS(u);
        pushNow = valid[u] && (qSize(u) < 4);
        nCyc[u]++;
        expUnd[u] = 1'b0;
        if ((nCyc[u] % d == 0) && (((nCyc[u] / d - 1) % (2 * s)) == 0)) begin
            curMode[u] = lj[u];
            if (qSize(u) == 0) begin
                curPair[u] = '0;
                expUnd[u]  = 1'b1;
                if (undCnt[u] < 65535) undCnt[u]++;
            end else if (u == 0) begin
                curPair[u] = q0.pop_front();
            end else begin
                curPair[u] = q1.pop_front();
            end
        end
        if (pushNow) begin
            if (u == 0) q0.push_back({8'h0, leftA, 8'h0, rightA});
            else        q1.push_back({16'h0, leftB, 16'h0, rightB});
        end
    endtask

    function automatic logic expSdin(int u);
        int k, b, pos, s, w;
        logic [31:0] smp;
        s = cfgS(u);
        w = cfgW(u);
        k = nCyc[u] / cfgD(u);
        if (k == 0) return 1'b0;
        b   = (k - 1) % (2 * s);
        pos = b % s;
        smp = (b >= s) ? curPair[u][31:0] : curPair[u][63:32];
        if (curMode[u])
            return (pos < w) ? smp[w-1-pos] : 1'b0;
        return (pos >= 1 && pos <= w) ? smp[w-pos] : 1'b0;
    endfunction

    function automatic logic expLrck(int u);
        int k, b, s;
        s = cfgS(u);
        k = nCyc[u] / cfgD(u);
        if (k == 0) return 1'b0;
        b = (k - 1) % (2 * s);
        if (curMode[u]) return (b >= s);
        return (b >= s - 1) && (b != 2 * s - 1);
    endfunction

    task automatic checkUnit(input int u);
        logic expSclk;
        expSclk = ((nCyc[u] % cfgD(u)) >= cfgD(u) / 2);
        checkOutput(unitTag("sclk", u), 32'(sclk[u]), 32'(expSclk));
        checkOutput(unitTag("lrck", u), 32'(lrck[u]), 32'(expLrck(u)));
        checkOutput(unitTag("sdin", u), 32'(sdin[u]), 32'(expSdin(u)));
        checkOutput(unitTag("underrun", u), 32'(und[u]), 32'(expUnd[u]));
        checkOutput(unitTag("ready", u), 32'(ready[u]), 32'(qSize(u) < 4));
`ifdef I2S_TX_UNDERRUN_CNT_EN
        checkOutput(unitTag("count", u), (u == 0) ? 32'(cntA) : 32'(cntB), 32'(undCnt[u]));
`endif
    endtask

    task automatic checkReset();
        for (int u = 0; u < 2; u++) begin
            checkOutput(unitTag("rstSclk", u), 32'(sclk[u]), 32'd0);
            checkOutput(unitTag("rstLrck", u), 32'(lrck[u]), 32'd0);
            checkOutput(unitTag("rstSdin", u), 32'(sdin[u]), 32'd0);
            checkOutput(unitTag("rstUnderrun", u), 32'(und[u]), 32'd0);
            checkOutput(unitTag("rstReady", u), 32'(ready[u]), 32'd1);
        end
`ifdef I2S_TX_UNDERRUN_CNT_EN
        checkOutput("rstCountA", 32'(cntA), 32'd0);
        checkOutput("rstCountB", 32'(cntB), 32'd0);
`endif
    endtask

    // ljSel: 0 forces I2S, 1 forces left-justified, 2 toggles rarely at random (mid-frame changes included).
    task automatic applyStimulus(input int validPct, input int ljSel, input bit directed);
        for (int u = 0; u < 2; u++) begin
            if (ljSel == 0)      lj[u] = 1'b0;
            else if (ljSel == 1) lj[u] = 1'b1;
            else if ($urandom_range(0, 199) == 0) lj[u] = ~lj[u];
            if (valid[u] && qSize(u) >= 4) continue;
            valid[u] = ($urandom_range(0, 99) < validPct);
            if (directed) begin
                if (u == 0) begin leftA = 24'hA5A5A5; rightA = 24'h5A5A5A; end
                else        begin leftB = 16'h8001;   rightB = 16'h7FFE;   end
            end else if (u == 0) begin
                leftA  = 24'($urandom);
                rightA = 24'($urandom);
            end else begin
                leftB  = 16'($urandom);
                rightB = 16'($urandom);
            end
        end
    endtask

    task automatic runCycles(input int cycles, input int validPct, input int ljSel, input bit directed);
        repeat (cycles) begin
            applyStimulus(validPct, ljSel, directed);
            @(posedge clk);
            #1;
            modelEdge(0);
            modelEdge(1);
            checkUnit(0);
            checkUnit(1);
        end
    endtask

    task automatic applyReset();
        valid = 2'b00;
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkReset();
        modelReset();
        repeat (2) @(posedge clk);
        #3;
        rstN = 1'b1;
    endtask

    task automatic runUntilBitA(input int target);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ((nCyc[0] / 4 > 0) && (((nCyc[0] / 4 - 1) % 64) == target)) begin
                reached = 1'b1;
                break;
            end
            runCycles(1, 0, 0, 1'b0);
        end
        checkOutput("reachBitA", 32'(reached), 32'd1);
    endtask

    initial begin
        rstN   = 1'b0;
        valid  = 2'b00;
        lj     = 2'b00;
        leftA  = '0;
        rightA = '0;
        leftB  = '0;
        rightB = '0;
        modelReset();
        #1;
        checkReset();
        #7;
        rstN = 1'b1;

        runCycles(1, 100, 0, 1'b1);
        runCycles(700, 0, 0, 1'b0);
        runCycles(1, 100, 1, 1'b1);
        runCycles(700, 0, 1, 1'b0);
        runCycles(3 * 256 + 20, 0, 2, 1'b0);
        runCycles(1500, 100, 2, 1'b0);
        runCycles(2000, 35, 2, 1'b0);

        applyReset();
        runCycles(3, 100, 0, 1'b0);
        runUntilBitA(10);
        applyReset();
        runCycles(600, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
